// File: rtl/code_history_display.sv
// code_history_display: keeps the last four encoder codes and scans them
// across a 4-digit common-anode seven-segment display. Digit 0 is the newest.
module code_history_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       code_valid,
  input  logic       clear,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [2:0] fill
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       hist_q [4];
  logic [2:0]       hist_d [4];
  logic [2:0]       fill_q, fill_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic [2:0]       digit_code;
  logic [6:0]       digit_pat;
  logic             dp_n;

  // Scan divider: hold each digit for SCAN_DIV cycles, then step to the next one.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    sel_d     = sel_q;
    if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      sel_d     = sel_q + 2'd1;
    end
  end

  // History shift register and fill count; clear wins over a simultaneous capture.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = hist_q[i];
    end
    fill_d = fill_q;
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        hist_d[i] = 3'd0;
      end
      fill_d = 3'd0;
    end else if (code_valid) begin
      hist_d[0] = code;
      for (int i = 1; i < 4; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  // Segment decode of the selected digit; empty digits are blanked and the
  // decimal point marks the newest entry.
  always_comb begin
    digit_code = hist_q[sel_q];
    case (digit_code)
      3'd0:    digit_pat = 7'h40;
      3'd1:    digit_pat = 7'h79;
      3'd2:    digit_pat = 7'h24;
      3'd3:    digit_pat = 7'h30;
      3'd4:    digit_pat = 7'h19;
      3'd5:    digit_pat = 7'h12;
      3'd6:    digit_pat = 7'h02;
      default: digit_pat = 7'h78;
    endcase
    dp_n = !((sel_q == 2'd0) && (fill_q != 3'd0));
    an_d = ~(4'b0001 << sel_q);
    if ({1'b0, sel_q} >= fill_q) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = {dp_n, digit_pat};
    end
  end

  // State and output registers; reset darkens the display and drops all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sel_q     <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= 3'd0;
      end
      fill_q    <= 3'd0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      sel_q     <= sel_d;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
      fill_q    <= fill_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_code_history_display.sv
// Directed bench for code_history_display: a SCAN_DIV=4 instance driven from
// a cycle-by-cycle vector table, and a SCAN_DIV=1 instance for back-to-back captures.
module tb_code_history_display;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [2:0] code;
    logic       clr;
    logic [3:0] an;
    logic [7:0] seg;
    logic [2:0] fill;
  } vec_t;

  logic clk = 1'b0;

  logic       rst4 = 1'b1, cv4 = 1'b0, clr4 = 1'b0;
  logic [2:0] code4 = 3'd0;
  logic [3:0] an4;
  logic [7:0] seg4;
  logic [2:0] fill4;

  logic       rst1 = 1'b1, cv1 = 1'b0, clr1 = 1'b0;
  logic [2:0] code1 = 3'd0;
  logic [3:0] an1;
  logic [7:0] seg1;
  logic [2:0] fill1;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  code_history_display #(.SCAN_DIV(4), .DIV_W(16)) u_dut4 (
    .clk(clk), .rst(rst4), .code(code4), .code_valid(cv4), .clear(clr4),
    .an(an4), .seg(seg4), .fill(fill4)
  );

  code_history_display #(.SCAN_DIV(1), .DIV_W(1)) u_dut1 (
    .clk(clk), .rst(rst1), .code(code1), .code_valid(cv1), .clear(clr1),
    .an(an1), .seg(seg1), .fill(fill1)
  );

  task automatic addVec(input logic r, input logic v, input logic [2:0] c, input logic cl,
                        input logic [3:0] a, input logic [7:0] s, input logic [2:0] f);
    vec_t e;
    e.rst = r; e.cv = v; e.code = c; e.clr = cl;
    e.an = a; e.seg = s; e.fill = f;
    vecs.push_back(e);
  endtask

  // Drive one cycle of inputs to the selected instance, then sample after the edge.
  task automatic applyStimulus(input bit which, input logic r, input logic v,
                               input logic [2:0] c, input logic cl);
    @(negedge clk);
    if (which) begin
      rst1 = r; cv1 = v; code1 = c; clr1 = cl;
    end else begin
      rst4 = r; cv4 = v; code4 = c; clr4 = cl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll1(input int idx, input logic [3:0] a, input logic [7:0] s,
                           input logic [2:0] f);
    checkOutput("div1_an", idx, {4'h0, an1}, {4'h0, a});
    checkOutput("div1_seg", idx, seg1, s);
    checkOutput("div1_fill", idx, {5'd0, fill1}, {5'd0, f});
  endtask

  initial begin
    // Reset, then a full scan rotation with nothing captured
    addVec(1, 0, 0, 0, 4'hF, 8'hFF, 0);
    addVec(1, 0, 0, 0, 4'hF, 8'hFF, 0);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'hE, 8'hFF, 0);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'hD, 8'hFF, 0);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'hB, 8'hFF, 0);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'h7, 8'hFF, 0);
    // Capture 3 while digit 0 is selected
    addVec(0, 1, 3, 0, 4'hE, 8'hFF, 1);
    for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 4'hE, 8'h30, 1);
    addVec(0, 0, 0, 0, 4'hD, 8'hFF, 1);
    // Captures 1,2,5,7,6 (history already holds 3)
    addVec(0, 1, 1, 0, 4'hD, 8'hFF, 2);
    addVec(0, 1, 2, 0, 4'hD, 8'hB0, 3);
    addVec(0, 1, 5, 0, 4'hD, 8'hF9, 4);
    addVec(0, 1, 7, 0, 4'hB, 8'hF9, 4);
    addVec(0, 1, 6, 0, 4'hB, 8'hA4, 4);
    for (int i = 0; i < 2; i++) addVec(0, 0, 0, 0, 4'hB, 8'h92, 4);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'h7, 8'hA4, 4);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 4'hE, 8'h02, 4);
    addVec(0, 0, 0, 0, 4'hD, 8'hF8, 4);
    // Clear together with a capture of 4: clear wins, scan keeps going
    addVec(0, 1, 4, 1, 4'hD, 8'hF8, 0);
    for (int i = 0; i < 2; i++) addVec(0, 0, 0, 0, 4'hD, 8'hFF, 0);
    // Build fill=3 at sel=2, then reset mid-scan
    addVec(0, 1, 4, 0, 4'hB, 8'hFF, 1);
    addVec(0, 1, 5, 0, 4'hB, 8'hFF, 2);
    addVec(0, 1, 6, 0, 4'hB, 8'hFF, 3);
    addVec(1, 0, 0, 0, 4'hF, 8'hFF, 0);
    for (int i = 0; i < 2; i++) addVec(0, 0, 0, 0, 4'hE, 8'hFF, 0);
    addVec(0, 1, 1, 0, 4'hE, 8'hFF, 1);
    addVec(0, 1, 2, 0, 4'hE, 8'h79, 2);
    addVec(0, 0, 0, 0, 4'hD, 8'hF9, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].rst, vecs[i].cv, vecs[i].code, vecs[i].clr);
      checkOutput("div4_an", i, {4'h0, an4}, {4'h0, vecs[i].an});
      checkOutput("div4_seg", i, seg4, vecs[i].seg);
      checkOutput("div4_fill", i, {5'd0, fill4}, {5'd0, vecs[i].fill});
    end

    // SCAN_DIV=1: digit rotates every cycle, consecutive captures 3,0,7 kept in order
    applyStimulus(1'b0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1, 0, 0, 0);
    checkAll1(0, 4'hF, 8'hFF, 0);
    applyStimulus(1'b1, 0, 1, 3, 0);
    checkAll1(1, 4'hE, 8'hFF, 1);
    applyStimulus(1'b1, 0, 1, 0, 0);
    checkAll1(2, 4'hD, 8'hFF, 2);
    applyStimulus(1'b1, 0, 1, 7, 0);
    checkAll1(3, 4'hB, 8'hFF, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    checkAll1(4, 4'h7, 8'hFF, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    checkAll1(5, 4'hE, 8'h78, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    checkAll1(6, 4'hD, 8'hC0, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    checkAll1(7, 4'hB, 8'hB0, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    checkAll1(8, 4'h7, 8'hFF, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_history_display.md
Name: code_history_display

Overview:
- Downstream consumer of the 3-bit binary encoder output (`code[2:0]` plus a one-cycle `code_valid` strobe).
- Keeps a history of the last 4 encoded values and shows them on a 4-digit multiplexed common-anode seven-segment display.
- Digit 0 (rightmost) always shows the newest value. Each older value moves one digit to the left.
- Contains a scan clock divider, a digit-select counter, a shift-register history, a fill counter, and registered segment/anode drivers.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit before scanning to the next. Legal range is 1 and up. Benches use 4.
- DIV_W, 16, width of the divider counter. Must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- code  input  3  encoded value from the binary encoder, range 0..7.
- code_valid  input  1  one-cycle strobe: capture `code` on this edge.
- clear  input  1  synchronous history clear; the scan keeps running.
- an  output  4  digit enables, active-low, exactly one low outside reset. `an[0]` = digit 0.
- seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- fill  output  3  number of valid history entries, 0..4.

Behaviour:
- Reset (`rst`=1 at an edge):
  - `hist[0..3]` = 0, `fill` = 0, divider `div_cnt` = 0, digit select `sel` = 0.
  - `an` = 4'b1111 and `seg` = 8'hFF (everything dark).
  - Reset applied mid-scan or mid-history discards all state on that edge.
- Divider:
  - If `div_cnt` == SCAN_DIV-1: `div_cnt` <= 0 and `sel` <= `sel`+1 (mod 4; 3 wraps to 0).
  - Otherwise `div_cnt` increments.
  - With SCAN_DIV=1, `sel` advances every cycle.
- Capture (`code_valid`=1, `clear`=0):
  - `hist[0]` <= `code`; `hist[i]` <= `hist[i-1]` for i=1..3; the oldest entry is dropped.
  - `fill` <= min(`fill`+1, 4); it saturates at 4.
- Clear (`clear`=1):
  - `hist` <= 0 and `fill` <= 0.
  - Clear has priority over a simultaneous `code_valid`; that code is lost.
  - Divider and `sel` are unaffected.
- Output registers (each cycle, outside reset):
  - `an` <= ~(4'b0001 << `sel`).
  - `seg` <= 8'hFF if `sel` >= `fill` (unused digits are blanked).
  - Otherwise `seg` <= {dp_n, pattern(`hist[sel]`)}.
  - dp_n = 0 (decimal point lit) only when `sel`==0 and `fill`!=0, marking the newest entry; otherwise 1.
- Latency: one registered stage.
  - `an`/`seg` reflect the `sel`/`hist`/`fill` values from the previous cycle.
  - A capture at edge N is visible on `seg` from edge N+1 if digit 0 is selected.
- Segment patterns (7 LSBs, active-low gfedcba):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78.
- `fill` output: drives the internal counter directly; no extra latency.
- Inputs are already synchronous to `clk`; no input synchroniser is required. `code` is ignored when `code_valid`=0.

Test Plan:
- Reset, then release with SCAN_DIV=4 → edge 1 after release: `an`=4'b1110, `seg`=8'hFF, `fill`=0. `an` steps 1110→1101→1011→0111→1110, each held 4 cycles.
- `code_valid` with `code`=3 while `sel`=0 → next cycle `seg`=8'h30 (dp lit), `fill`=1. At `sel`=1..3, `seg`=8'hFF.
- Five captures 1,2,5,7,6 → `fill`=4. Digits 0..3 show 6,7,5,2: `seg` = 8'h02, 8'hF8, 8'h92, 8'hA4. The 1 is dropped.
- `clear` and `code_valid` (`code`=4) together → `fill`=0 and all digits blank; scan phase continues without a glitch.
- Assert `rst` mid-scan with `fill`=3 and `sel`=2 → next edge: `an`=4'hF, `seg`=8'hFF, `fill`=0, `sel` restarts at 0.
- SCAN_DIV=1 → `an` rotates every cycle. Captures back-to-back on consecutive cycles are all recorded in order.
